dmem_responder: RTL and testbench

Data-memory responder at the far end of the CPU's MEM-stage data port. It accepts byte, halfword and word loads and stores on the 14-bit byte address, sign/mask bus. It performs them against a word-wide synchronous block RAM, merging stores with a read-modify-write sequence. It returns load data aligned and extended, asserts `stall_o` while busy, and exposes one memory-mapped LED register.

---
 rtl/dmem_pkg.sv | 81 ++++++++
 rtl/dmem_if.sv | 21 ++
 rtl/dmem_bram.sv | 21 ++
 rtl/dmem_responder.sv | 116 +++++++++++
 tb/tb_dmem_responder.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types, size encodings and lane helpers for the data-memory responder.
package dmem_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_MERGE = 2'd2,
    ST_WR    = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [ADDR_W-1:0] LED_ADDR_DEFAULT = 14'h2000;

  // Request as captured at accept time; addr already has its low bits aligned.
  typedef struct packed {
    logic              is_store;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        sign_mask;
  } req_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      default: misaligned = |off;
    endcase
  endfunction

  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: align_off = off;
      SZ_HALF: align_off = {off[1], 1'b0};
      default: align_off = 2'b00;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [1:0]        off,
                                                    input logic [2:0]        sign_mask);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (sign_mask[1:0])
      SZ_BYTE: load_extend = sign_mask[2] ? {{24{b[7]}}, b} : {24'b0, b};
      SZ_HALF: load_extend = sign_mask[2] ? {{16{h[15]}}, h} : {16'b0, h};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] old,
                                                    input logic [DATA_W-1:0] data,
                                                    input logic [1:0]        off,
                                                    input logic [1:0]        size);
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] data_sh;
    case (size)
      SZ_BYTE: begin
        mask    = 32'h0000_00FF << {off, 3'b000};
        data_sh = {24'b0, data[7:0]} << {off, 3'b000};
      end
      SZ_HALF: begin
        mask    = 32'h0000_FFFF << {off[1], 4'b0000};
        data_sh = {16'b0, data[15:0]} << {off[1], 4'b0000};
      end
      default: begin
        mask    = '1;
        data_sh = data;
      end
    endcase
    store_merge = (old & ~mask) | (data_sh & mask);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// CPU MEM-stage data port: request signals from the CPU, results back from the responder.
interface dmem_if;
  logic [13:0] addr_i;
  logic [31:0] wr_data_i;
  logic        memwrite_i;
  logic        memread_i;
  logic [2:0]  sign_mask_i;
  logic [31:0] rd_data_o;
  logic        stall_o;
  logic        err_o;

  modport master (
    output addr_i, wr_data_i, memwrite_i, memread_i, sign_mask_i,
    input  rd_data_o, stall_o, err_o
  );

  modport slave (
    input  addr_i, wr_data_i, memwrite_i, memread_i, sign_mask_i,
    output rd_data_o, stall_o, err_o
  );
endinterface

// File: rtl/dmem_bram.sv
// Single-port word RAM with registered read; read returns the pre-write contents.
module dmem_bram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          clk_i,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata     <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: loads/stores of byte/half/word against a word RAM
// using read-modify-write for stores, plus one memory-mapped LED register.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] LED_ADDR    = LED_ADDR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  dmem_if.slave       bus,
  input  logic [7:0]  led_i,
  output logic [7:0]  led_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] merged_q, merged_d;
  logic [7:0]        led_q, led_d;

  logic              req_c;
  logic              err_c;
  logic              req_is_led_c;
  logic              ram_re, ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign req_c        = bus.memread_i | bus.memwrite_i;
  assign req_is_led_c = (req_q.addr[13:2] == LED_ADDR[13:2]);

  // Next-state, capture and RAM control.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rd_data_d = rd_data_q;
    merged_d  = merged_q;
    led_d     = led_q;
    err_c     = 1'b0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = req_q.addr[AW+1:2];

    case (state_q)
      ST_IDLE: begin
        ram_addr = bus.addr_i[AW+1:2];
        if (req_c) begin
          ram_re          = 1'b1;
          err_c           = misaligned(bus.sign_mask_i[1:0], bus.addr_i[1:0]);
          req_d.is_store  = bus.memwrite_i;
          req_d.addr      = {bus.addr_i[13:2], align_off(bus.sign_mask_i[1:0], bus.addr_i[1:0])};
          req_d.wdata     = bus.wr_data_i;
          req_d.sign_mask = bus.sign_mask_i;
          state_d         = ST_RD;
        end
      end
      ST_RD: begin
        if (req_is_led_c) begin
          if (req_q.is_store) led_d = req_q.wdata[7:0];
          else rd_data_d = load_extend({24'b0, led_i}, req_q.addr[1:0], req_q.sign_mask);
          state_d = ST_IDLE;
        end else if (req_q.is_store) begin
          state_d = ST_MERGE;
        end else begin
          rd_data_d = load_extend(ram_rdata, req_q.addr[1:0], req_q.sign_mask);
          state_d   = ST_IDLE;
        end
      end
      ST_MERGE: begin
        merged_d = store_merge(ram_rdata, req_q.wdata, req_q.addr[1:0], req_q.sign_mask[1:0]);
        state_d  = ST_WR;
      end
      ST_WR: begin
        ram_we  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      rd_data_q <= '0;
      merged_q  <= '0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rd_data_q <= rd_data_d;
      merged_q  <= merged_d;
      led_q     <= led_d;
    end
  end

  dmem_bram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_bram (
    .clk_i (clk_i),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (merged_q),
    .rdata (ram_rdata)
  );

  assign bus.rd_data_o = rd_data_q;
  assign bus.stall_o   = (state_q != ST_IDLE) | req_c;
  assign bus.err_o     = err_c;
  assign led_o         = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed vector bench for dmem_responder: access table plus a reset-during-store sequence.
module tb_dmem_responder;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] led_in;
  logic [7:0] led_out;
  int         checks = 0;
  int         errors = 0;

  dmem_if bus();

  dmem_responder dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus),
    .led_i  (led_in),
    .led_o  (led_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [2:0]  sm;
    logic [7:0]  led_in;
    int          exp_stall;
    int          exp_err;
    logic [31:0] exp_rd;
    logic [7:0]  exp_led;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [13:0] a,
                              input logic [31:0] d, input logic [2:0] sm, input logic [7:0] li,
                              input int st, input int er, input logic [31:0] erd,
                              input logic [7:0] eled);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.wdata = d; v.sm = sm; v.led_in = li;
    v.exp_stall = st; v.exp_err = er; v.exp_rd = erd; v.exp_led = eled;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; drives a request, drops it after accept,
  // scrambles the bus to prove the captured copy is used, and returns at the first idle negedge.
  task automatic access(input logic wr, input logic rd, input logic [13:0] addr,
                        input logic [31:0] wdata, input logic [2:0] sm,
                        output int n_stall, output int n_err);
    bus.memwrite_i  = wr;
    bus.memread_i   = rd;
    bus.addr_i      = addr;
    bus.wr_data_i   = wdata;
    bus.sign_mask_i = sm;
    n_stall = 0;
    n_err   = 0;
    #1;
    while (bus.stall_o && n_stall < 20) begin
      n_stall++;
      if (bus.err_o) n_err++;
      @(posedge clk);
      #1;
      bus.memwrite_i  = 1'b0;
      bus.memread_i   = 1'b0;
      bus.addr_i      = 14'h0FFE;
      bus.wr_data_i   = 32'h5555_AAAA;
      bus.sign_mask_i = 3'b110;
      @(negedge clk);
    end
    if (n_stall >= 20) begin
      errors++;
      $display("FAIL access_timeout actual=%0d expected=<20", n_stall);
    end
  endtask

  initial begin
    int ns, ne;

    vecs[0]  = mk(1, 0, 14'h0010, 32'hDEAD_BEEF, 3'b011, 8'h00, 4, 0, 32'h0000_0000, 8'h00);
    vecs[1]  = mk(0, 1, 14'h0010, 32'h0,         3'b011, 8'h00, 2, 0, 32'hDEAD_BEEF, 8'h00);
    vecs[2]  = mk(1, 0, 14'h0010, 32'h0,         3'b011, 8'h00, 4, 0, 32'hDEAD_BEEF, 8'h00);
    vecs[3]  = mk(1, 0, 14'h0013, 32'h0000_0080, 3'b000, 8'h00, 4, 0, 32'hDEAD_BEEF, 8'h00);
    vecs[4]  = mk(0, 1, 14'h0013, 32'h0,         3'b100, 8'h00, 2, 0, 32'hFFFF_FF80, 8'h00);
    vecs[5]  = mk(0, 1, 14'h0010, 32'h0,         3'b011, 8'h00, 2, 0, 32'h8000_0000, 8'h00);
    vecs[6]  = mk(1, 0, 14'h0010, 32'h8001_7FFF, 3'b011, 8'h00, 4, 0, 32'h8000_0000, 8'h00);
    vecs[7]  = mk(0, 1, 14'h0012, 32'h0,         3'b101, 8'h00, 2, 0, 32'hFFFF_8001, 8'h00);
    vecs[8]  = mk(0, 1, 14'h0012, 32'h0,         3'b001, 8'h00, 2, 0, 32'h0000_8001, 8'h00);
    vecs[9]  = mk(1, 0, 14'h0010, 32'hABCD_1234, 3'b001, 8'h00, 4, 0, 32'h0000_8001, 8'h00);
    vecs[10] = mk(0, 1, 14'h0010, 32'h0,         3'b011, 8'h00, 2, 0, 32'h8001_1234, 8'h00);
    vecs[11] = mk(0, 1, 14'h0011, 32'h0,         3'b011, 8'h00, 2, 1, 32'h8001_1234, 8'h00);
    vecs[12] = mk(0, 1, 14'h0011, 32'h0,         3'b000, 8'h00, 2, 0, 32'h0000_0012, 8'h00);
    vecs[13] = mk(0, 1, 14'h0012, 32'h0,         3'b100, 8'h00, 2, 0, 32'h0000_0001, 8'h00);
    vecs[14] = mk(1, 0, 14'h0013, 32'h0000_BEEF, 3'b001, 8'h00, 4, 1, 32'h0000_0001, 8'h00);
    vecs[15] = mk(0, 1, 14'h0010, 32'h0,         3'b011, 8'h00, 2, 0, 32'hBEEF_1234, 8'h00);
    vecs[16] = mk(0, 1, 14'h0010, 32'h0,         3'b101, 8'h00, 2, 0, 32'h0000_1234, 8'h00);
    vecs[17] = mk(1, 0, 14'h0000, 32'h1111_1111, 3'b011, 8'h00, 4, 0, 32'h0000_1234, 8'h00);
    vecs[18] = mk(1, 0, 14'h2000, 32'hFFFF_FF5A, 3'b000, 8'h00, 2, 0, 32'h0000_1234, 8'h5A);
    vecs[19] = mk(0, 1, 14'h0000, 32'h0,         3'b011, 8'h00, 2, 0, 32'h1111_1111, 8'h5A);
    vecs[20] = mk(0, 1, 14'h2000, 32'h0,         3'b100, 8'hC3, 2, 0, 32'hFFFF_FFC3, 8'h5A);
    vecs[21] = mk(0, 1, 14'h2000, 32'h0,         3'b000, 8'hC3, 2, 0, 32'h0000_00C3, 8'h5A);
    vecs[22] = mk(1, 1, 14'h0020, 32'hCAFE_F00D, 3'b011, 8'h00, 4, 0, 32'h0000_00C3, 8'h5A);
    vecs[23] = mk(0, 1, 14'h0020, 32'h0,         3'b011, 8'h00, 2, 0, 32'hCAFE_F00D, 8'h5A);

    rstn            = 1'b0;
    led_in          = 8'h00;
    bus.memwrite_i  = 1'b0;
    bus.memread_i   = 1'b0;
    bus.addr_i      = '0;
    bus.wr_data_i   = '0;
    bus.sign_mask_i = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_data", bus.rd_data_o, 32'h0);
    chk("reset_led", 32'(led_out), 32'h0);
    chk("reset_stall", 32'(bus.stall_o), 32'h0);
    chk("reset_err", 32'(bus.err_o), 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      led_in = vecs[i].led_in;
      access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].sm, ns, ne);
      chk($sformatf("v%0d_stall_cycles", i), 32'(ns), 32'(vecs[i].exp_stall));
      chk($sformatf("v%0d_err_pulses", i), 32'(ne), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_rd_data", i), bus.rd_data_o, vecs[i].exp_rd);
      chk($sformatf("v%0d_led", i), 32'(led_out), 32'(vecs[i].exp_led));
    end

    // Reset lands while a store to 0x0020 is in MERGE: nothing may be written.
    bus.memwrite_i  = 1'b1;
    bus.memread_i   = 1'b0;
    bus.addr_i      = 14'h0020;
    bus.wr_data_i   = 32'h1234_5678;
    bus.sign_mask_i = 3'b011;
    @(posedge clk);
    #1;
    bus.memwrite_i = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_merge_led", 32'(led_out), 32'h0);
    chk("rst_merge_stall", 32'(bus.stall_o), 32'h0);
    chk("rst_merge_rd_data", bus.rd_data_o, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    access(1'b0, 1'b1, 14'h0020, 32'h0, 3'b011, ns, ne);
    chk("rst_merge_reload_stall", 32'(ns), 32'd2);
    chk("rst_merge_reload_data", bus.rd_data_o, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
